// File: rtl/pcm_fifo_player_if.sv
// FIFO read-side bundle for the PCM player: empty flag, read data and read strobe.
// The player is the master (drives fifo_rd); the FIFO is the slave.
interface pcm_fifo_player_if #(
    parameter int unsigned dbits = 1
);
    logic             fifo_empty;
    logic [dbits-1:0] fifo_dout;
    logic             fifo_rd;

    modport master (
        input  fifo_empty,
        input  fifo_dout,
        output fifo_rd
    );

    modport slave (
        output fifo_empty,
        output fifo_dout,
        input  fifo_rd
    );
endinterface

// File: rtl/pcm_fifo_player.sv
// pcm_fifo_player: consumer end of the 1-bit PCM audio FIFO.
// Once per sample tick it pops one sample using a high-then-settle rd strobe
// (the FIFO reacts to the falling edge of rd through a 2-flop detector plus an
// output register), then presents the sample on audio_out until the next
// latch or until playback is disabled. A sticky underrun flag records ticks
// that found the FIFO empty while enabled.
module pcm_fifo_player #(
    parameter int unsigned dbits      = 1,
    parameter int unsigned CLK_DIV    = 2500,
    parameter int unsigned RD_HIGH    = 2,
    parameter logic        IDLE_LEVEL = 1'b0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    pcm_fifo_player_if.master fifo,
    output logic [dbits-1:0]  audio_out,
    output logic              playing,
    output logic              underrun,
    input  logic              clr_underrun
);

    localparam int unsigned CNT_W      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    // Detector delay (2) plus FIFO output register (1).
    localparam int unsigned SETTLE_CYC = 3;
    localparam int unsigned PH_W       = $clog2(RD_HIGH + SETTLE_CYC + 1);
    localparam logic [dbits-1:0] IDLE_VEC = {dbits{IDLE_LEVEL}};

    typedef enum logic [1:0] {
        WAIT_TICK,
        RD_PULSE,
        SETTLE,
        LATCH
    } state_t;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tick;

    state_t           state_q;
    logic [PH_W-1:0]  ph_q;
    logic             rd_q;
    logic [dbits-1:0] audio_q;
    logic             playing_q;
    logic             underrun_q;

    // Sample-rate divider: free-running, independent of enable.
    always_comb begin
        tick  = (cnt_q == CNT_W'(CLK_DIV - 1));
        cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
    end

    // Tick counter register.
    always_ff @(posedge clock) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Read sequencer with registered strobe, sample and status outputs.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q    <= WAIT_TICK;
            ph_q       <= '0;
            rd_q       <= 1'b0;
            audio_q    <= IDLE_VEC;
            playing_q  <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            if (clr_underrun) begin
                underrun_q <= 1'b0;
            end
            case (state_q)
                WAIT_TICK: begin
                    if (tick) begin
                        if (!enable) begin
                            audio_q   <= IDLE_VEC;
                            playing_q <= 1'b0;
                        end else if (fifo.fifo_empty) begin
                            // clear request wins over a same-cycle set
                            if (!clr_underrun) begin
                                underrun_q <= 1'b1;
                            end
                            playing_q <= 1'b0;
                        end else begin
                            rd_q    <= 1'b1;
                            ph_q    <= '0;
                            state_q <= RD_PULSE;
                        end
                    end
                end
                RD_PULSE: begin
                    if (ph_q == PH_W'(RD_HIGH - 1)) begin
                        rd_q    <= 1'b0;
                        ph_q    <= '0;
                        state_q <= SETTLE;
                    end else begin
                        ph_q <= ph_q + PH_W'(1);
                    end
                end
                SETTLE: begin
                    if (ph_q == PH_W'(SETTLE_CYC - 1)) begin
                        ph_q    <= '0;
                        state_q <= LATCH;
                    end else begin
                        ph_q <= ph_q + PH_W'(1);
                    end
                end
                LATCH: begin
                    audio_q   <= fifo.fifo_dout;
                    playing_q <= 1'b1;
                    state_q   <= WAIT_TICK;
                end
                default: begin
                    rd_q    <= 1'b0;
                    ph_q    <= '0;
                    state_q <= WAIT_TICK;
                end
            endcase
        end
    end

    assign fifo.fifo_rd = rd_q;
    assign audio_out    = audio_q;
    assign playing      = playing_q;
    assign underrun     = underrun_q;

endmodule
